// File: rtl/frog_pkg.sv
// Shared constants for the frogger button front-end: directions, button indices,
// repeat FSM encoding and the fixed-priority pick used for arbitration.
package frog_pkg;

    localparam int unsigned NUM_BTN   = 4;
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        RS_IDLE   = 2'd0,
        RS_DELAY  = 2'd1,
        RS_REPEAT = 2'd2
    } rep_state_e;

    // Lowest set index wins (up > down > left > right); DIR_UP when empty.
    function automatic dir_t prio_dir(input logic [NUM_BTN-1:0] req);
        dir_t d;
        d = DIR_UP;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (req[i]) d = dir_t'(i);
        end
        return d;
    endfunction

endpackage

// File: rtl/frog_move_if.sv
// Move-request handshake from the button front-end to the frogger core.
interface frog_move_if;
    import frog_pkg::*;

    logic move_valid;
    dir_t move_dir;
    logic move_ready;

    modport master (output move_valid, output move_dir, input move_ready);
    modport slave  (input move_valid, input move_dir, output move_ready);
endinterface

// File: rtl/frog_input_ctrl_button_debounce.sv
// One button: 2-flop synchronizer, debounce counter, stable active-high level
// and a one-cycle press pulse registered alongside the level rise.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1_q, s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          sync_pressed;

    assign sync_pressed = ~s2_q;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_pressed != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
                press_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= btn_n_i;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;
endmodule

// File: rtl/frog_input_ctrl.sv
// Button front-end top: per-button debounce, pending request bits, fixed-priority
// output register on a valid/ready handshake, and the held-button auto-repeat FSM.
module frog_input_ctrl
    import frog_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    output logic [NUM_BTN-1:0] pressed,
    frog_move_if.master        mv
);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    logic [NUM_BTN-1:0] btn_n, level, press;

    assign btn_n = {right, left, down, up};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .reset   (reset),
            .btn_n_i (btn_n[g]),
            .level_o (level[g]),
            .press_o (press[g])
        );
    end

    assign pressed = level;

    rep_state_e         state_q, state_d;
    logic [RW-1:0]      rcnt_q, rcnt_d;
    dir_t               held_q, held_c;
    logic               held_vld_q, any_c;
    logic [NUM_BTN-1:0] rep_set_c;

    assign held_c = prio_dir(level);
    assign any_c  = |level;

    // A fresh press of the held button restarts the delay; any change of held drops to idle.
    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        rep_set_c = '0;
        if (REPEAT_EN == 0) begin
            state_d = RS_IDLE;
            rcnt_d  = '0;
        end else if (any_c && press[held_c]) begin
            state_d = RS_DELAY;
            rcnt_d  = '0;
        end else if (!any_c || !held_vld_q || (held_c != held_q)) begin
            state_d = RS_IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                RS_DELAY: begin
                    if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
                        rep_set_c[held_c] = 1'b1;
                        state_d           = RS_REPEAT;
                        rcnt_d            = '0;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                RS_REPEAT: begin
                    if (rcnt_q == RW'(REPEAT_PERIOD - 1)) begin
                        rep_set_c[held_c] = 1'b1;
                        rcnt_d            = '0;
                    end else begin
                        rcnt_d = rcnt_q + RW'(1);
                    end
                end
                default: begin
                    state_d = RS_IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic               valid_q, valid_d;
    dir_t               dir_q, dir_d, sel_c;
    logic               load_c;

    assign sel_c  = prio_dir(pending_q);
    assign load_c = (!valid_q || mv.move_ready) && (|pending_q);

    // New sets are OR-ed in after the clear so a same-edge set keeps the bit pending.
    always_comb begin
        pending_d = pending_q;
        valid_d   = valid_q;
        dir_d     = dir_q;
        if (load_c) begin
            valid_d          = 1'b1;
            dir_d            = sel_c;
            pending_d[sel_c] = 1'b0;
        end else if (mv.move_ready) begin
            valid_d = 1'b0;
        end
        pending_d = pending_d | press | rep_set_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RS_IDLE;
            rcnt_q     <= '0;
            held_q     <= DIR_UP;
            held_vld_q <= 1'b0;
            pending_q  <= '0;
            valid_q    <= 1'b0;
            dir_q      <= DIR_UP;
        end else begin
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            held_q     <= held_c;
            held_vld_q <= any_c;
            pending_q  <= pending_d;
            valid_q    <= valid_d;
            dir_q      <= dir_d;
        end
    end

    assign mv.move_valid = valid_q;
    assign mv.move_dir   = dir_q;
endmodule
